memory_arbiter: RTL and testbench
=================================

# memory_arbiter

Single-port RAM arbiter directly downstream of the data cache and instruction cache. It accepts word requests from both caches and serialises them onto one RAM port. It returns wait and load data to the requester that owns the grant. The data cache has priority, and a bounded starvation guard gives the instruction cache a grant after a fixed number of data-cache words.

## Interface
Parameters:
- STARVE_MAX, 4: maximum consecutive data-cache words completed while iREN is pending before the icache is forced a grant; legal range 1–15.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- iREN  in  1  icache read request.
- iaddr  in  32  icache word address.
- iwait  out  1  icache stall; low for exactly the cycle iload is valid.
- iload  out  32  icache read data.
- dREN  in  1  dcache read request.
- dWEN  in  1  dcache write request.
- daddr  in  32  dcache word address.
- dstore  in  32  dcache write data.
- dwait  out  1  dcache stall; low for exactly the completion cycle.
- dload  out  32  dcache read data.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3.
- mem_error  out  1  sticky flag, set on any ERROR seen while granted.
- err_count  out  8  saturating count of ERROR cycles while granted.

## Operation
- States: ARB, DGRANT, IGRANT. The state is held in a register. Reset state is ARB.
- ARB:
  - RAM enables are low and both wait signals are high.
  - Next state is chosen from the current requests:
    - dreq = dREN|dWEN.
    - dreq with !iREN → DGRANT.
    - iREN with !dreq → IGRANT.
    - both asserted → IGRANT if starve_cnt == STARVE_MAX, else DGRANT.
    - neither → ARB.
- DGRANT:
  - Combinationally, ramWEN=dWEN, ramREN=dREN&!dWEN (a write wins over a read if both are asserted), ramaddr=daddr, ramstore=dstore, dload=ramload.
  - ramstate==ACCESS → dwait=0, next ARB.
  - ramstate==ERROR → dwait stays 1; mem_error set; err_count+1 (saturates at 255); grant held, so the word is retried.
  - dreq drops before ACCESS → next ARB; RAM enables follow the inputs low in that same cycle.
- IGRANT:
  - Combinationally, ramREN=iREN, ramWEN=0, ramaddr=iaddr, ramstore=0, iload=ramload.
  - Completion, error and withdrawal rules are the same as DGRANT, using iwait and iREN.
- Starvation counter starve_cnt, width 4 bits:
  - Increments when a dcache word completes while iREN=1, saturating at STARVE_MAX.
  - Clears on icache completion.
  - Clears in any cycle where iREN=0.
- Non-granted requester: wait=1 and load=0.
- Every completed word returns through ARB. A two-word dcache burst therefore re-arbitrates between its words, so the icache may interleave once the guard fires.

## Timing
- Reset values, also the values in every ARB cycle:
  - iwait=1, dwait=1.
  - iload=0, dload=0.
  - ramREN=0, ramWEN=0, ramaddr=0, ramstore=0.
- Reset-only values: mem_error=0, err_count=0, starve_cnt=0, state ARB.
- Latency: request seen in ARB at cycle t → RAM enables driven at t+1 → wait low in the first ACCESS cycle. Minimum latency is 2 cycles for a zero-wait RAM.
- All outputs are combinational from the state register, the live requester inputs and ramstate. There are no registered data paths.
- Asynchronous reset mid-grant:
  - Drops the RAM enables immediately.
  - The interrupted word is lost.
  - Requesters must reissue after reset.
- ramstate FREE or BUSY while granted: hold the grant and keep wait high, indefinitely.
- ACCESS or ERROR seen in ARB: ignored; no counter changes.

## Structure
- The team package (cpu_types_pkg) holds ramstate_t, with FREE/BUSY/ACCESS/ERROR encoded 0–3, and word_t.
- arb_state_t (ARB/DGRANT/IGRANT) is local to the module.
- Single module, no sub-modules. The state register, starvation counter and error counter are each one always_ff block, and output steering is one always_comb block.
- The module pins map onto the existing caches_if signals (dREN/dWEN/daddr/dstore/dwait/dload and iREN/iaddr/iwait/iload).

## Test plan
- Reset with dREN=1 asserted → all outputs hold reset values while nRST=0. After release: DGRANT on the next edge, then dwait=0 on the first ACCESS.
- Icache read only, iaddr=0x0000_0040, RAM returns 0xDEADBEEF after 2 BUSY cycles → iwait low in exactly one cycle with iload=0xDEADBEEF, ramWEN never 1.
- Simultaneous iREN and dWEN (daddr=0x100, dstore=0x1234), both held → dcache granted first: ramWEN=1, ramaddr=0x100, ramstore=0x1234.
- iREN held with continuous dREN and STARVE_MAX=4 → exactly 4 dcache completions, then one icache completion, then the dcache resumes; starve_cnt reads 0 after the icache word.
- ramstate=ERROR for 3 cycles during DGRANT, then ACCESS → dwait stays high through the errors, err_count=3, mem_error=1 and stays set; the completion then proceeds normally.
- dREN withdrawn mid-grant before ACCESS → ARB on the next edge, ramREN=0 in the withdrawal cycle, no dwait pulse, starve_cnt unchanged.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU memory-side types: RAM status encoding, word type and counter widths.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  // RAM port status as reported by the memory model / controller.
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  localparam int STARVE_W = 4;  // starvation counter width
  localparam int ERRCNT_W = 8;  // saturating error counter width

endpackage

// File: rtl/memory_arbiter.sv
// Single-port RAM arbiter for dcache + icache; dcache has priority, bounded icache starvation.
// Latency: request seen in ARB at t -> RAM enables at t+1 -> wait low on first ACCESS (min 2 cycles).
// Backpressure: requester holds its request while its wait is high; FREE/BUSY/ERROR hold the grant.
//
// Ports:
//   CLK, nRST                     clock, async active-low reset
//   iREN, iaddr / iwait, iload    icache read request and response
//   dREN, dWEN, daddr, dstore     dcache request
//   dwait, dload                  dcache response
//   ramREN, ramWEN, ramaddr,
//   ramstore / ramload, ramstate  RAM port
//   mem_error, err_count          sticky error flag and saturating ERROR-cycle count
module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        mem_error,
  output logic [7:0]  err_count
);

  typedef enum logic [1:0] {
    ARB    = 2'd0,
    DGRANT = 2'd1,
    IGRANT = 2'd2
  } arb_state_t;

  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  arb_state_t            r_state;
  arb_state_t            w_next_state;
  logic [STARVE_W-1:0]   r_starve_cnt;
  logic [ERRCNT_W-1:0]   r_err_count;
  logic                  r_mem_error;

  ramstate_t             w_ramstate;
  logic                  w_dreq;
  logic                  w_d_done;
  logic                  w_i_done;
  logic                  w_grant_err;

  assign w_ramstate  = ramstate_t'(ramstate);
  assign w_dreq      = dREN | dWEN;
  // A word completes only if its requester is still asking in the ACCESS cycle.
  assign w_d_done    = (r_state == DGRANT) && w_dreq && (w_ramstate == ACCESS);
  assign w_i_done    = (r_state == IGRANT) && iREN   && (w_ramstate == ACCESS);
  // ACCESS/ERROR seen in ARB is stray and must not touch the counters.
  assign w_grant_err = (r_state != ARB) && (w_ramstate == ERROR);

  assign mem_error = r_mem_error;
  assign err_count = r_err_count;

  // State register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= ARB;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic. Every completion or withdrawal goes back through ARB,
  // so a dcache burst re-arbitrates between words.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ARB: begin
        if (w_dreq && iREN) begin
          w_next_state = (r_starve_cnt == STARVE_LIM) ? IGRANT : DGRANT;
        end else if (w_dreq) begin
          w_next_state = DGRANT;
        end else if (iREN) begin
          w_next_state = IGRANT;
        end else begin
          w_next_state = ARB;
        end
      end
      DGRANT: begin
        if (!w_dreq || (w_ramstate == ACCESS)) begin
          w_next_state = ARB;
        end
      end
      IGRANT: begin
        if (!iREN || (w_ramstate == ACCESS)) begin
          w_next_state = ARB;
        end
      end
      default: w_next_state = ARB;
    endcase
  end

  // Starvation guard: counts dcache words finished while the icache waits.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_starve_cnt <= '0;
    end else if (!iREN || w_i_done) begin
      r_starve_cnt <= '0;
    end else if (w_d_done && (r_starve_cnt < STARVE_LIM)) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

  // Error tracking: sticky flag plus saturating count of ERROR cycles while granted.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_mem_error <= 1'b0;
      r_err_count <= '0;
    end else if (w_grant_err) begin
      r_mem_error <= 1'b1;
      if (r_err_count != '1) begin
        r_err_count <= r_err_count + 1'b1;
      end
    end
  end

  // Output steering: purely combinational from state, live requester inputs and ramstate.
  always_comb begin
    iwait    = 1'b1;
    iload    = '0;
    dwait    = 1'b1;
    dload    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    case (r_state)
      DGRANT: begin
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;  // write wins if both are asserted
        ramaddr  = daddr;
        ramstore = dstore;
        dload    = ramload;
        dwait    = ~w_d_done;
      end
      IGRANT: begin
        ramREN   = iREN;
        ramaddr  = iaddr;
        iload    = ramload;
        iwait    = ~w_i_done;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: vector table, directed corner sequences, random vs. model.
// Latency: n/a.
// Backpressure: n/a.
module tb_memory_arbiter;

  localparam int SM = 4;

  logic        CLK, nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic        iwait, dwait, ramREN, ramWEN, mem_error;
  logic [31:0] iload, dload, ramaddr, ramstore;
  logic [7:0]  err_count;

  int checks = 0;
  int errors = 0;

  memory_arbiter #(.STARVE_MAX(SM)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate),
    .mem_error(mem_error), .err_count(err_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        iwait;
    logic [31:0] iload;
    logic        dwait;
    logic [31:0] dload;
    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] store;
    logic        merr;
    logic [7:0]  ecnt;
  } out_t;

  typedef struct packed {
    logic        i, d, w;
    logic [1:0]  rs;
    logic [31:0] ld;
    logic        e_iw, e_dw, e_ren, e_wen;
    logic [31:0] e_addr, e_store, e_il, e_dl;
  } vec_t;

  vec_t tbl [13];

  // Reference model state: who owns the RAM (0 nobody, 1 dcache, 2 icache).
  int m_owner, m_starve, m_err;
  bit m_merr;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic out_t actual_out();
    out_t a;
    a = {iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, mem_error, err_count};
    return a;
  endfunction

  function automatic out_t model_out();
    out_t e;
    bit   dreq, acc;
    dreq = dREN || dWEN;
    acc  = (ramstate == 2'd2);
    e = '0;
    e.iwait = 1'b1;
    e.dwait = 1'b1;
    e.merr  = m_merr;
    e.ecnt  = 8'(m_err);
    if (m_owner == 1) begin
      e.wen   = dWEN;
      e.ren   = dREN && !dWEN;
      e.addr  = daddr;
      e.store = dstore;
      e.dload = ramload;
      e.dwait = !(dreq && acc);
    end else if (m_owner == 2) begin
      e.ren   = iREN;
      e.addr  = iaddr;
      e.iload = ramload;
      e.iwait = !(iREN && acc);
    end
    return e;
  endfunction

  task automatic model_step();
    bit dreq, acc, d_done, i_done;
    int nxt;
    dreq   = dREN || dWEN;
    acc    = (ramstate == 2'd2);
    d_done = (m_owner == 1) && dreq && acc;
    i_done = (m_owner == 2) && iREN && acc;
    if (m_owner != 0 && ramstate == 2'd3) begin
      m_merr = 1'b1;
      if (m_err < 255) m_err++;
    end
    nxt = m_owner;
    if (m_owner == 0) begin
      if (dreq && iREN) nxt = (m_starve == SM) ? 2 : 1;
      else if (dreq)    nxt = 1;
      else if (iREN)    nxt = 2;
    end else if (m_owner == 1) begin
      if (!dreq || acc) nxt = 0;
    end else begin
      if (!iREN || acc) nxt = 0;
    end
    if (!iREN || i_done) m_starve = 0;
    else if (d_done && m_starve < SM) m_starve++;
    m_owner = nxt;
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; ramstate = 2'd0;
    repeat (2) @(posedge CLK);
    #1;
    nRST = 1'b1;
    m_owner = 0; m_starve = 0; m_err = 0; m_merr = 1'b0;
  endtask

  out_t  rst_exp;
  string order;

  initial begin
    // {i,d,w,rs,ramload, exp iwait,dwait,ren,wen,addr,store,iload,dload}
    tbl[0]  = '{1'b0,1'b0,1'b0,2'd0,32'h0000AAAA, 1'b1,1'b1,1'b0,1'b0,32'h0,  32'h0,   32'h0,        32'h0};
    tbl[1]  = '{1'b1,1'b0,1'b0,2'd2,32'h00001111, 1'b1,1'b1,1'b0,1'b0,32'h0,  32'h0,   32'h0,        32'h0};
    tbl[2]  = '{1'b1,1'b0,1'b0,2'd1,32'h00002222, 1'b1,1'b1,1'b1,1'b0,32'h40, 32'h0,   32'h00002222, 32'h0};
    tbl[3]  = '{1'b1,1'b0,1'b0,2'd1,32'h00003333, 1'b1,1'b1,1'b1,1'b0,32'h40, 32'h0,   32'h00003333, 32'h0};
    tbl[4]  = '{1'b1,1'b0,1'b0,2'd2,32'hDEADBEEF, 1'b0,1'b1,1'b1,1'b0,32'h40, 32'h0,   32'hDEADBEEF, 32'h0};
    tbl[5]  = '{1'b1,1'b0,1'b1,2'd0,32'h00000005, 1'b1,1'b1,1'b0,1'b0,32'h0,  32'h0,   32'h0,        32'h0};
    tbl[6]  = '{1'b1,1'b0,1'b1,2'd2,32'h00000006, 1'b1,1'b0,1'b0,1'b1,32'h100,32'h1234,32'h0,        32'h6};
    tbl[7]  = '{1'b0,1'b1,1'b0,2'd0,32'h00000007, 1'b1,1'b1,1'b0,1'b0,32'h0,  32'h0,   32'h0,        32'h0};
    tbl[8]  = '{1'b0,1'b1,1'b0,2'd1,32'h00000008, 1'b1,1'b1,1'b1,1'b0,32'h100,32'h1234,32'h0,        32'h8};
    tbl[9]  = '{1'b0,1'b0,1'b0,2'd2,32'h00000009, 1'b1,1'b1,1'b0,1'b0,32'h100,32'h1234,32'h0,        32'h9};
    tbl[10] = '{1'b0,1'b1,1'b1,2'd2,32'h0000000A, 1'b1,1'b1,1'b0,1'b0,32'h0,  32'h0,   32'h0,        32'h0};
    tbl[11] = '{1'b0,1'b1,1'b1,2'd2,32'h0000000B, 1'b1,1'b0,1'b0,1'b1,32'h100,32'h1234,32'h0,        32'hB};
    tbl[12] = '{1'b0,1'b0,1'b0,2'd3,32'h0000000C, 1'b1,1'b1,1'b0,1'b0,32'h0,  32'h0,   32'h0,        32'h0};

    rst_exp = '0;
    rst_exp.iwait = 1'b1;
    rst_exp.dwait = 1'b1;

    // Reset held with a live dcache request and a stray ACCESS.
    nRST = 1'b0; iREN = 1'b0; dREN = 1'b1; dWEN = 1'b0; ramstate = 2'd2;
    iaddr = 32'h40; daddr = 32'h100; dstore = 32'h1234; ramload = 32'h55;
    @(negedge CLK);
    chk("reset_outputs_0", 160'(actual_out()), 160'(rst_exp));
    @(negedge CLK);
    chk("reset_outputs_1", 160'(actual_out()), 160'(rst_exp));
    next_cycle();
    nRST = 1'b1;
    @(negedge CLK);
    chk("post_reset_arb", 160'({dwait, ramREN}), 160'(2'b10));
    next_cycle();
    @(negedge CLK);
    chk("post_reset_dgrant", 160'({dwait, ramREN, dload}), 160'({1'b0, 1'b1, 32'h55}));
    next_cycle();
    dREN = 1'b0;

    // Table-driven cycle sequence from a clean reset.
    do_reset();
    iaddr = 32'h40; daddr = 32'h100; dstore = 32'h1234;
    for (int k = 0; k < 13; k++) begin
      iREN = tbl[k].i; dREN = tbl[k].d; dWEN = tbl[k].w;
      ramstate = tbl[k].rs; ramload = tbl[k].ld;
      @(negedge CLK);
      chk($sformatf("vec%0d", k),
          160'({iwait, dwait, ramREN, ramWEN, ramaddr, ramstore, iload, dload}),
          160'({tbl[k].e_iw, tbl[k].e_dw, tbl[k].e_ren, tbl[k].e_wen,
                tbl[k].e_addr, tbl[k].e_store, tbl[k].e_il, tbl[k].e_dl}));
      if (k == 9) chk("withdraw_starve", 160'(dut.r_starve_cnt), 160'(0));
      next_cycle();
    end
    @(negedge CLK);
    chk("no_err_from_arb", 160'({mem_error, err_count}), 160'(0));
    next_cycle();

    // Three ERROR cycles during a dcache grant, then ACCESS.
    dREN = 1'b1; dWEN = 1'b0; iREN = 1'b0; ramstate = 2'd0;
    next_cycle();
    for (int k = 0; k < 3; k++) begin
      ramstate = 2'd3;
      @(negedge CLK);
      chk($sformatf("err_dwait%0d", k), 160'({dwait, ramREN}), 160'(2'b11));
      next_cycle();
    end
    ramstate = 2'd2; ramload = 32'hCAFE0001;
    @(negedge CLK);
    chk("err_then_access", 160'({dwait, dload, mem_error, err_count}),
        160'({1'b0, 32'hCAFE0001, 1'b1, 8'd3}));
    next_cycle();
    dREN = 1'b0; ramstate = 2'd0;
    @(negedge CLK);
    chk("err_sticky", 160'({mem_error, err_count}), 160'({1'b1, 8'd3}));
    next_cycle();

    // Starvation guard with both caches asking continuously.
    order = "";
    iREN = 1'b1; dREN = 1'b1; dWEN = 1'b0; ramstate = 2'd2;
    for (int k = 0; k < 12; k++) begin
      @(negedge CLK);
      if (!dwait) order = {order, "D"};
      if (!iwait) order = {order, "I"};
      if (k == 8)  chk("starve_at_limit", 160'(dut.r_starve_cnt), 160'(SM));
      if (k == 10) chk("starve_cleared", 160'(dut.r_starve_cnt), 160'(0));
      next_cycle();
    end
    checks++;
    if (order != "DDDDID") begin
      errors++;
      $display("FAIL starve_order actual=%s required=DDDDID", order);
    end

    // Asynchronous reset in the middle of a dcache grant.
    iREN = 1'b0; dREN = 1'b1; ramstate = 2'd1;
    next_cycle();
    @(negedge CLK);
    chk("midgrant_before", 160'(ramREN), 160'(1));
    #1;
    nRST = 1'b0;
    #1;
    chk("midgrant_async", 160'({ramREN, dwait, ramaddr}), 160'({1'b0, 1'b1, 32'h0}));
    do_reset();

    // Randomized traffic against the reference model.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(3) == 0) iREN = ~iREN;
      if ($urandom_range(3) == 0) dREN = ~dREN;
      if ($urandom_range(5) == 0) dWEN = ~dWEN;
      iaddr = $urandom; daddr = $urandom; dstore = $urandom; ramload = $urandom;
      case ($urandom_range(7))
        0:       ramstate = 2'd0;
        1:       ramstate = 2'd1;
        6, 7:    ramstate = 2'd3;
        default: ramstate = 2'd2;
      endcase
      @(negedge CLK);
      chk($sformatf("rand%0d", n), 160'(actual_out()), 160'(model_out()));
      chk($sformatf("rand_starve%0d", n), 160'(dut.r_starve_cnt), 160'(m_starve));
      model_step();
      next_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
